axis_sc_fifo: RTL and testbench
===============================

Name: axis_sc_fifo

Overview:
Single-clock AXI-Stream FIFO with first-word-fall-through output, used to pass counter/trigger words between register-map logic and datapath logic inside one clock domain. It provides valid/ready handshakes on both sides, with fill-level, room, full and empty status. Depth is a power of two set by ADDRESS_WIDTH; ADDRESS_WIDTH=0 gives a one-entry holding register.

Parameters:
DATA_WIDTH, 64, payload width in bits (1..1024).
ADDRESS_WIDTH, 1, log2 of depth; DEPTH = 2**ADDRESS_WIDTH (0 gives depth 1; max 10).

Ports:
aclk  input  1  clock; all logic on rising edge.
areset  input  1  asynchronous, active-high reset.
s_axis_valid  input  1  write request.
s_axis_ready  output  1  FIFO can accept a word.
s_axis_data  input  DATA_WIDTH  write payload.
s_axis_full  output  1  FIFO holds DEPTH words.
s_axis_room  output  ADDRESS_WIDTH+1  free entries (DEPTH - level).
m_axis_valid  output  1  m_axis_data holds the oldest word.
m_axis_ready  input  1  read acknowledge.
m_axis_data  output  DATA_WIDTH  oldest stored word.
m_axis_level  output  ADDRESS_WIDTH+1  stored entries.
m_axis_empty  output  1  level == 0.

Behaviour:
- Reset (async assert, sync release): level 0, s_axis_ready=1, s_axis_full=0, s_axis_room=DEPTH, m_axis_valid=0, m_axis_empty=1, m_axis_data=0, pointers 0.
- Write happens on a clock edge when s_axis_valid && s_axis_ready; s_axis_data is stored at the write pointer, and the pointer wraps modulo DEPTH.
- Read happens on a clock edge when m_axis_valid && m_axis_ready; the read pointer advances and wraps modulo DEPTH.
- s_axis_ready = !s_axis_full. It is a registered function of level only and never depends on s_axis_valid. A write while full is ignored and data is lost; the producer must gate valid with ready.
- m_axis_valid = !m_axis_empty, derived from registered state. A read while empty is ignored.
- Latency: a word accepted at edge N is visible on m_axis_data with m_axis_valid=1 after edge N (first-word-fall-through). There is no combinational bypass from s_axis to m_axis.
- Simultaneous write and read when 0 < level < DEPTH: level unchanged, both pointers advance.
- Full and m_axis_ready=1: read occurs, no write (ready was 0). The write is accepted on the next cycle.
- Empty and s_axis_valid=1: write only.
- m_axis_data stays stable while m_axis_valid && !m_axis_ready.
- Status: level = writes - reads. room = DEPTH - level. full = (level == DEPTH). empty = (level == 0). All are registered and updated on the same edge as the pointers.
- ADDRESS_WIDTH=0: a single register with a valid flag. ready = !valid, so steady-state throughput is one word per 2 cycles.
- Storage may be flops or distributed RAM. Storage contents are not reset; only pointers and flags are reset.
- Reset asserted mid-operation: the FIFO empties immediately and all outputs take their reset values asynchronously.

Optional Feature:
- Macro: AXIS_SC_FIFO_TLAST_EN.
- Defined: adds ports s_axis_tlast (input, 1) and m_axis_tlast (output, 1). tlast is stored with each entry and follows the same timing as m_axis_data. m_axis_tlast resets to 0.
- Undefined: neither port exists and no storage is added for it.

Test Plan:
1. DATA_WIDTH=64, ADDRESS_WIDTH=1: release reset -> ready=1, valid=0, empty=1, level=0, room=2, data=0.
2. Write 0x0000_0001_DEAD_BEEF, hold m_axis_ready=0 -> next cycle valid=1, data=0x0000_0001_DEAD_BEEF, level=1, room=1. Data holds for 5 cycles.
3. Write 0xA then 0xB back-to-back with no reads -> full=1, ready=0, level=2. Attempted write of 0xC is ignored. Reads return 0xA then 0xB, then empty=1.
4. Level=1 (0x11), write 0x22 and read in the same cycle -> level stays 1, next output 0x22. Over 10 cycles of streaming at level 1, the sequence order is preserved with no loss.
5. ADDRESS_WIDTH=0, s_axis_valid held high, m_axis_ready held high -> ready toggles 1,0,1,0. Each word appears once with 1-cycle latency.
6. Level=2, pulse areset asynchronously mid-cycle -> valid=0, empty=1, level=0, ready=1 immediately. The first post-reset write reads back correctly.

Source files
------------

// File: rtl/axis_sc_fifo.sv
// axis_sc_fifo: single-clock AXI-Stream FIFO with first-word-fall-through output.
// Depth is 2**ADDRESS_WIDTH; ADDRESS_WIDTH=0 degenerates to a one-entry holding register.
// Optional feature macro: AXIS_SC_FIFO_TLAST_EN adds s_axis_tlast/m_axis_tlast, stored with each word.
module axis_sc_fifo #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 1
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     s_axis_valid,
    output logic                     s_axis_ready,
    input  logic [DATA_WIDTH-1:0]    s_axis_data,
`ifdef AXIS_SC_FIFO_TLAST_EN
    input  logic                     s_axis_tlast,
    output logic                     m_axis_tlast,
`endif
    output logic                     s_axis_full,
    output logic [ADDRESS_WIDTH:0]   s_axis_room,
    output logic                     m_axis_valid,
    input  logic                     m_axis_ready,
    output logic [DATA_WIDTH-1:0]    m_axis_data,
    output logic [ADDRESS_WIDTH:0]   m_axis_level,
    output logic                     m_axis_empty
);

    localparam int DEPTH     = 1 << ADDRESS_WIDTH;
    localparam int PTR_W     = (ADDRESS_WIDTH > 0) ? ADDRESS_WIDTH : 1;
    localparam int MEM_DEPTH = 1 << PTR_W;
    localparam int LVL_W     = ADDRESS_WIDTH + 1;
`ifdef AXIS_SC_FIFO_TLAST_EN
    localparam int WORD_W    = DATA_WIDTH + 1;
`else
    localparam int WORD_W    = DATA_WIDTH;
`endif

    // Storage is intentionally not reset; only pointers, flags and the output word are.
    logic [WORD_W-1:0] mem [MEM_DEPTH];

    logic [WORD_W-1:0] word_in;
    logic [WORD_W-1:0] head_reg;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [LVL_W-1:0]  level_reg, level_next;
    logic [LVL_W-1:0]  room_reg;
    logic              full_reg;
    logic              empty_reg;
    logic              wr_en;
    logic              rd_en;
    logic              bypass;

`ifdef AXIS_SC_FIFO_TLAST_EN
    assign word_in = {s_axis_tlast, s_axis_data};
`else
    assign word_in = s_axis_data;
`endif

    // Handshakes only look at registered flags, so ready never depends on valid.
    assign wr_en = s_axis_valid && !full_reg;
    assign rd_en = m_axis_ready && !empty_reg;

    // Pointer wrap; with a single entry both pointers are pinned at zero.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (ADDRESS_WIDTH == 0)
            return '0;
        else
            return p + 1'b1;
    endfunction

    // Next-state pointers and fill level from this cycle's handshakes.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        if (wr_en)
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        if (rd_en)
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        case ({wr_en, rd_en})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    // The incoming word becomes the new head when it lands where the read pointer will sit
    // (FIFO empty, or a single word being replaced by a simultaneous read and write).
    assign bypass = wr_en && (rd_ptr_next == wr_ptr_reg);

    // Pointer, level and status registers, all updated on the same edge.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            room_reg   <= LVL_W'(DEPTH);
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            room_reg   <= LVL_W'(DEPTH) - level_next;
            full_reg   <= (level_next == LVL_W'(DEPTH));
            empty_reg  <= (level_next == '0);
        end
    end

    // Registered head word: prefetches the next oldest entry so the output is first-word-fall-through.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            head_reg <= '0;
        end else if (level_next != '0) begin
            head_reg <= bypass ? word_in : mem[rd_ptr_next];
        end
    end

    // Payload storage write port.
    always_ff @(posedge aclk) begin
        if (wr_en)
            mem[wr_ptr_reg] <= word_in;
    end

    assign s_axis_ready = !full_reg;
    assign s_axis_full  = full_reg;
    assign s_axis_room  = room_reg;
    assign m_axis_valid = !empty_reg;
    assign m_axis_empty = empty_reg;
    assign m_axis_level = level_reg;
    assign m_axis_data  = head_reg[DATA_WIDTH-1:0];
`ifdef AXIS_SC_FIFO_TLAST_EN
    assign m_axis_tlast = head_reg[DATA_WIDTH];
`endif

endmodule

// File: tb/tb_axis_sc_fifo.sv
// Testbench for axis_sc_fifo: a depth-2 instance (64-bit) and a depth-1 instance (8-bit)
// run side by side and are compared every cycle against queue-based reference models.
module tb_axis_sc_fifo;

    logic        aclk;
    logic        areset;

    // Depth-2 instance
    logic        s_valid, s_ready, s_full, m_valid, m_ready, m_empty;
    logic [63:0] s_data, m_data;
    logic [1:0]  s_room, m_level;

    // Depth-1 instance
    logic        z_s_valid, z_s_ready, z_s_full, z_m_valid, z_m_ready, z_m_empty;
    logic [7:0]  z_s_data, z_m_data;
    logic [0:0]  z_s_room, z_m_level;

`ifdef AXIS_SC_FIFO_TLAST_EN
    logic        s_tlast, m_tlast, z_s_tlast, z_m_tlast;
    assign s_tlast   = s_data[0];
    assign z_s_tlast = z_s_data[0];
`endif

    int checks = 0;
    int errors = 0;

    logic [63:0] q[$];
    logic [7:0]  zq[$];

    axis_sc_fifo #(.DATA_WIDTH(64), .ADDRESS_WIDTH(1)) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_valid(s_valid), .s_axis_ready(s_ready), .s_axis_data(s_data),
`ifdef AXIS_SC_FIFO_TLAST_EN
        .s_axis_tlast(s_tlast), .m_axis_tlast(m_tlast),
`endif
        .s_axis_full(s_full), .s_axis_room(s_room),
        .m_axis_valid(m_valid), .m_axis_ready(m_ready), .m_axis_data(m_data),
        .m_axis_level(m_level), .m_axis_empty(m_empty)
    );

    axis_sc_fifo #(.DATA_WIDTH(8), .ADDRESS_WIDTH(0)) dut_z (
        .aclk(aclk), .areset(areset),
        .s_axis_valid(z_s_valid), .s_axis_ready(z_s_ready), .s_axis_data(z_s_data),
`ifdef AXIS_SC_FIFO_TLAST_EN
        .s_axis_tlast(z_s_tlast), .m_axis_tlast(z_m_tlast),
`endif
        .s_axis_full(z_s_full), .s_axis_room(z_s_room),
        .m_axis_valid(z_m_valid), .m_axis_ready(z_m_ready), .m_axis_data(z_m_data),
        .m_axis_level(z_m_level), .m_axis_empty(z_m_empty)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output of both instances against the models.
    task automatic check_all();
        int n  = q.size();
        int zn = zq.size();
        chk("ready", 64'(s_ready), 64'(n < 2));
        chk("full",  64'(s_full),  64'(n == 2));
        chk("valid", 64'(m_valid), 64'(n > 0));
        chk("empty", 64'(m_empty), 64'(n == 0));
        chk("level", 64'(m_level), 64'(n));
        chk("room",  64'(s_room),  64'(2 - n));
        if (n > 0) begin
            chk("data", m_data, q[0]);
`ifdef AXIS_SC_FIFO_TLAST_EN
            chk("tlast", 64'(m_tlast), 64'(q[0][0]));
`endif
        end
        chk("z_ready", 64'(z_s_ready), 64'(zn == 0));
        chk("z_full",  64'(z_s_full),  64'(zn == 1));
        chk("z_valid", 64'(z_m_valid), 64'(zn == 1));
        chk("z_empty", 64'(z_m_empty), 64'(zn == 0));
        chk("z_level", 64'(z_m_level), 64'(zn));
        chk("z_room",  64'(z_s_room),  64'(1 - zn));
        if (zn > 0) begin
            chk("z_data", 64'(z_m_data), 64'(zq[0]));
`ifdef AXIS_SC_FIFO_TLAST_EN
            chk("z_tlast", 64'(z_m_tlast), 64'(zq[0][0]));
`endif
        end
    endtask

    // One clock: decide acceptance from the model's occupancy, advance the models, then check.
    task automatic step();
        bit wr, rd, zwr, zrd;
        wr  = s_valid   && (q.size()  < 2);
        rd  = m_ready   && (q.size()  > 0);
        zwr = z_s_valid && (zq.size() < 1);
        zrd = z_m_ready && (zq.size() > 0);
        @(posedge aclk);
        if (rd)  void'(q.pop_front());
        if (wr)  q.push_back(s_data);
        if (zrd) void'(zq.pop_front());
        if (zwr) zq.push_back(z_s_data);
        #1;
        check_all();
    endtask

    initial begin
        areset    = 1'b1;
        s_valid   = 1'b0; s_data   = '0; m_ready   = 1'b0;
        z_s_valid = 1'b0; z_s_data = '0; z_m_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge aclk);
        #6 areset = 1'b0;
        #1;
        check_all();
        chk("rst_data", m_data, 64'h0);
        chk("rst_z_data", 64'(z_m_data), 64'h0);
        step();
        chk("idle_data", m_data, 64'h0);

        // Single word with first-word-fall-through; held while not read
        s_valid = 1'b1; s_data = 64'h0000_0001_DEAD_BEEF;
        step();
        chk("fwft_data", m_data, 64'h0000_0001_DEAD_BEEF);
        s_valid = 1'b0; s_data = 64'h5555;
        repeat (5) step();
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;

        // Fill to full, attempted write ignored, drain in order
        s_valid = 1'b1; s_data = 64'hA; step();
        s_data = 64'hB; step();
        chk("full_flag", 64'(s_full), 64'h1);
        s_data = 64'hC; step();
        step();
        s_valid = 1'b0; m_ready = 1'b1;
        chk("head_A", m_data, 64'hA);
        step();
        chk("head_B", m_data, 64'hB);
        step();
        chk("drained", 64'(m_empty), 64'h1);
        m_ready = 1'b0;

        // Simultaneous read/write at level 1 keeps level and order
        s_valid = 1'b1; s_data = 64'h11; step();
        m_ready = 1'b1; s_data = 64'h22; step();
        chk("stream_lvl", 64'(m_level), 64'h1);
        chk("stream_head", m_data, 64'h22);
        for (int i = 0; i < 10; i++) begin
            s_data = {$urandom, $urandom};
            step();
        end
        s_valid = 1'b0;
        step();
        m_ready = 1'b0;

        // Depth-1 instance: ready alternates under continuous valid/ready
        z_s_valid = 1'b1; z_m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            z_s_data = 8'($urandom);
            step();
            chk("z_toggle", 64'(z_s_ready), 64'(i % 2));
        end
        z_s_valid = 1'b0; z_m_ready = 1'b0;
        step();

        // Randomised traffic on both instances
        for (int i = 0; i < 300; i++) begin
            s_valid   = 1'($urandom_range(0, 1));
            m_ready   = ($urandom_range(0, 3) != 0);
            s_data    = {$urandom, $urandom};
            z_s_valid = 1'($urandom_range(0, 1));
            z_m_ready = 1'($urandom_range(0, 1));
            z_s_data  = 8'($urandom);
            step();
        end

        // Asynchronous reset mid-cycle at level 2
        s_valid = 1'b0; m_ready = 1'b0; z_s_valid = 1'b0; z_m_ready = 1'b0;
        step();
        s_valid = 1'b1; s_data = 64'h1234; z_s_valid = 1'b1; z_s_data = 8'h5A;
        step();
        step();
        s_valid = 1'b0; z_s_valid = 1'b0;
        chk("pre_rst_level", 64'(m_level), 64'h2);
        #3 areset = 1'b1;
        #1;
        q.delete();
        zq.delete();
        check_all();
        chk("async_data", m_data, 64'h0);
        #2 areset = 1'b0;
        s_valid = 1'b1; s_data = 64'hFEED_F00D_0BAD_CAFE;
        step();
        s_valid = 1'b0; m_ready = 1'b1;
        chk("post_rst_data", m_data, 64'hFEED_F00D_0BAD_CAFE);
        step();
        m_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
